// File: rtl/ame_grad_accum.sv
// Gradient statistics for one Sobel Gx/Gy block pair. Both blocks are captured
// independently, then reduced one row per cycle into |G| sums, peak magnitude and direction.
module ame_grad_accum #(
  parameter int          COMP_DATA_BITS = 8,
  parameter int          SUM_BITS       = COMP_DATA_BITS + 4,
  parameter int unsigned FLAT_THRES     = 16
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      gx_done_i,
  input  logic [3:0][3:0][COMP_DATA_BITS-1:0]       gx_data_i,
  input  logic                                      gy_done_i,
  input  logic [3:0][3:0][COMP_DATA_BITS-1:0]       gy_data_i,
  output logic                                      busy_o,
  output logic                                      accum_done_o,
  output logic [SUM_BITS-1:0]                       sum_gx_o,
  output logic [SUM_BITS-1:0]                       sum_gy_o,
  output logic [COMP_DATA_BITS:0]                   mag_max_o,
  output logic [1:0]                                dir_o,
  output logic                                      ovf_o
);

  localparam int N = COMP_DATA_BITS;
  localparam int M = COMP_DATA_BITS + 1;

  typedef logic [3:0][3:0][N-1:0] blk_t;
  typedef enum logic [2:0] {IDLE, ROW_0, ROW_1, ROW_2, ROW_3} state_t;

  // Unsigned magnitude; the most negative input maps to 2^(N-1), which fits in N bits.
  function automatic logic [N-1:0] abs_val(input logic [N-1:0] v);
    logic signed [N-1:0] s;
    s = v;
    return s[N-1] ? (~v + N'(1)) : v;
  endfunction

  function automatic logic [1:0] dir_of(input logic [SUM_BITS-1:0] sx,
                                        input logic [SUM_BITS-1:0] sy);
    logic [SUM_BITS-1:0] thr;
    thr = SUM_BITS'(FLAT_THRES);
    if (sx < thr && sy < thr) return 2'b00;
    else if (sx > sy)          return 2'b01;
    else if (sy > sx)          return 2'b10;
    else                       return 2'b11;
  endfunction

  state_t              state_q, state_d;
  blk_t                gx_buf_q, gx_buf_d, gy_buf_q, gy_buf_d;
  blk_t                wk_gx_q, wk_gx_d, wk_gy_q, wk_gy_d;
  logic                gx_vld_q, gx_vld_d, gy_vld_q, gy_vld_d;
  logic                ovf_q, ovf_d;
  logic [SUM_BITS-1:0] acc_gx_q, acc_gx_d, acc_gy_q, acc_gy_d;
  logic [M-1:0]        acc_max_q, acc_max_d;
  logic [SUM_BITS-1:0] res_gx_q, res_gx_d, res_gy_q, res_gy_d;
  logic [M-1:0]        res_max_q, res_max_d;
  logic [1:0]          res_dir_q, res_dir_d;
  logic                done_q, done_d;
  logic                consume;

  logic [1:0]          ridx;
  logic [3:0][N-1:0]   ax, ay;
  logic [3:0][M-1:0]   mc;
  logic [SUM_BITS-1:0] row_sx, row_sy, fin_gx, fin_gy;
  logic [M-1:0]        row_max;

  always_comb begin
    case (state_q)
      ROW_1:   ridx = 2'd1;
      ROW_2:   ridx = 2'd2;
      ROW_3:   ridx = 2'd3;
      default: ridx = 2'd0;
    endcase
  end

  // Row reduction: four magnitudes per channel, summed, plus running peak of |Gx|+|Gy|.
  always_comb begin
    row_sx  = '0;
    row_sy  = '0;
    row_max = acc_max_q;
    for (int c = 0; c < 4; c++) begin
      ax[c]  = abs_val(wk_gx_q[ridx][c]);
      ay[c]  = abs_val(wk_gy_q[ridx][c]);
      mc[c]  = M'(ax[c]) + M'(ay[c]);
      row_sx = row_sx + SUM_BITS'(ax[c]);
      row_sy = row_sy + SUM_BITS'(ay[c]);
      if (mc[c] > row_max) row_max = mc[c];
    end
    fin_gx = acc_gx_q + row_sx;
    fin_gy = acc_gy_q + row_sy;
  end

  always_comb begin
    state_d   = state_q;
    wk_gx_d   = wk_gx_q;
    wk_gy_d   = wk_gy_q;
    acc_gx_d  = acc_gx_q;
    acc_gy_d  = acc_gy_q;
    acc_max_d = acc_max_q;
    res_gx_d  = res_gx_q;
    res_gy_d  = res_gy_q;
    res_max_d = res_max_q;
    res_dir_d = res_dir_q;
    done_d    = 1'b0;
    consume   = 1'b0;

    if (state_q != IDLE) begin
      acc_gx_d  = fin_gx;
      acc_gy_d  = fin_gy;
      acc_max_d = row_max;
    end

    case (state_q)
      IDLE: begin
        if (gx_vld_q && gy_vld_q) begin
          consume = 1'b1;
          state_d = ROW_0;
        end
      end
      ROW_0: state_d = ROW_1;
      ROW_1: state_d = ROW_2;
      ROW_2: state_d = ROW_3;
      ROW_3: begin
        res_gx_d  = fin_gx;
        res_gy_d  = fin_gy;
        res_max_d = row_max;
        res_dir_d = dir_of(fin_gx, fin_gy);
        done_d    = 1'b1;
        if (gx_vld_q && gy_vld_q) begin
          consume = 1'b1;
          state_d = ROW_0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume) begin
      wk_gx_d   = gx_buf_q;
      wk_gy_d   = gy_buf_q;
      acc_gx_d  = '0;
      acc_gy_d  = '0;
      acc_max_d = '0;
    end
  end

  // Capture: a done pulse always wins over the same-cycle consume, keeping the flag set.
  always_comb begin
    gx_buf_d = gx_done_i ? gx_data_i : gx_buf_q;
    gy_buf_d = gy_done_i ? gy_data_i : gy_buf_q;
    gx_vld_d = gx_done_i | (gx_vld_q & ~consume);
    gy_vld_d = gy_done_i | (gy_vld_q & ~consume);
    ovf_d    = ovf_q | (gx_done_i & gx_vld_q & ~consume)
                     | (gy_done_i & gy_vld_q & ~consume);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gx_buf_q  <= '0;
      gy_buf_q  <= '0;
      gx_vld_q  <= 1'b0;
      gy_vld_q  <= 1'b0;
      ovf_q     <= 1'b0;
      wk_gx_q   <= '0;
      wk_gy_q   <= '0;
      acc_gx_q  <= '0;
      acc_gy_q  <= '0;
      acc_max_q <= '0;
      res_gx_q  <= '0;
      res_gy_q  <= '0;
      res_max_q <= '0;
      res_dir_q <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gx_buf_q  <= gx_buf_d;
      gy_buf_q  <= gy_buf_d;
      gx_vld_q  <= gx_vld_d;
      gy_vld_q  <= gy_vld_d;
      ovf_q     <= ovf_d;
      wk_gx_q   <= wk_gx_d;
      wk_gy_q   <= wk_gy_d;
      acc_gx_q  <= acc_gx_d;
      acc_gy_q  <= acc_gy_d;
      acc_max_q <= acc_max_d;
      res_gx_q  <= res_gx_d;
      res_gy_q  <= res_gy_d;
      res_max_q <= res_max_d;
      res_dir_q <= res_dir_d;
      done_q    <= done_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign accum_done_o = done_q;
  assign sum_gx_o     = res_gx_q;
  assign sum_gy_o     = res_gy_q;
  assign mag_max_o    = res_max_q;
  assign dir_o        = res_dir_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_ame_grad_accum.sv
// Directed bench for ame_grad_accum: expected statistics are queued when a pair is
// presented and compared, with latency, when accum_done_o fires.
module tb_ame_grad_accum;

  localparam int N  = 8;
  localparam int SB = N + 4;

  typedef logic [3:0][3:0][N-1:0] blk_t;
  typedef struct {
    int sgx;
    int sgy;
    int mag;
    int dir;
    int due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          gx_done = 1'b0, gy_done = 1'b0;
  blk_t          gx_data = '0, gy_data = '0;
  logic          busy_o, accum_done_o, ovf_o;
  logic [SB-1:0] sum_gx_o, sum_gy_o;
  logic [N:0]    mag_max_o;
  logic [1:0]    dir_o;

  ame_grad_accum #(.COMP_DATA_BITS(N), .SUM_BITS(SB), .FLAT_THRES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .gx_done_i(gx_done), .gx_data_i(gx_data),
    .gy_done_i(gy_done), .gy_data_i(gy_data),
    .busy_o(busy_o), .accum_done_o(accum_done_o),
    .sum_gx_o(sum_gx_o), .sum_gy_o(sum_gy_o),
    .mag_max_o(mag_max_o), .dir_o(dir_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t q[$];
  exp_t mon_e;
  int   last_due = -100;
  bit   chk_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic blk_t fill(input int v);
    blk_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r][c] = N'(v);
    return b;
  endfunction

  function automatic blk_t rnd_blk();
    blk_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r][c] = N'($urandom_range(0, 255));
    return b;
  endfunction

  function automatic exp_t model(input blk_t gx, input blk_t gy);
    exp_t e;
    logic signed [N-1:0] vx, vy;
    int a, b;
    e.sgx = 0; e.sgy = 0; e.mag = 0; e.due = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        vx = gx[r][c];
        vy = gy[r][c];
        a = (vx < 0) ? -int'(vx) : int'(vx);
        b = (vy < 0) ? -int'(vy) : int'(vy);
        e.sgx += a;
        e.sgy += b;
        if (a + b > e.mag) e.mag = a + b;
      end
    if (e.sgx < 16 && e.sgy < 16) e.dir = 0;
    else if (e.sgx > e.sgy)       e.dir = 1;
    else if (e.sgy > e.sgx)       e.dir = 2;
    else                          e.dir = 3;
    return e;
  endfunction

  // Called in the cycle the later done pulse is driven.
  task automatic push(input blk_t gx, input blk_t gy);
    exp_t e;
    e = model(gx, gy);
    e.due = (cyc + 6 > last_due + 4) ? cyc + 6 : last_due + 4;
    last_due = e.due;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_gx(input blk_t gx);
    gx_data = gx; gx_done = 1'b1;
    tick();
    gx_done = 1'b0;
  endtask

  task automatic drive_gy(input blk_t gy);
    gy_data = gy; gy_done = 1'b1;
    tick();
    gy_done = 1'b0;
  endtask

  task automatic drive_pair(input blk_t gx, input blk_t gy, input int gap, input bit track);
    gx_data = gx; gx_done = 1'b1;
    if (gap == 0) begin
      gy_data = gy; gy_done = 1'b1;
      if (track) push(gx, gy);
    end
    tick();
    gx_done = 1'b0; gy_done = 1'b0;
    if (gap > 0) begin
      repeat (gap - 1) tick();
      if (track) push(gx, gy);
      drive_gy(gy);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    chk("drain", q.size(), 0);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, accum_done_o, 0);
    chk({tag, "_sum_gx"}, sum_gx_o, 0);
    chk({tag, "_sum_gy"}, sum_gy_o, 0);
    chk({tag, "_mag"}, mag_max_o, 0);
    chk({tag, "_dir"}, dir_o, 0);
    chk({tag, "_ovf"}, ovf_o, 0);
  endtask

  always @(negedge clk) begin
    if (accum_done_o) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("sum_gx", sum_gx_o, mon_e.sgx);
        chk("sum_gy", sum_gy_o, mon_e.sgy);
        chk("mag_max", mag_max_o, mon_e.mag);
        chk("dir", dir_o, mon_e.dir);
        chk("latency_cycle", cyc, mon_e.due);
      end
    end
    if (chk_busy) chk("busy_b2b", busy_o, 1);
  end

  initial begin
    blk_t g;
    blk_t p1x, p1y, p2x, p2y, p3x, p3y;

    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_busy", busy_o, 0);

    drive_pair(fill(3), fill(-2), 0, 1);
    drain();
    chk("uniform_ovf", ovf_o, 0);

    g = fill(0);
    g[2][1] = 8'h80;
    drive_pair(g, fill(127), 3, 1);
    drain();

    drive_pair(fill(0), fill(0), 0, 1);
    drain();

    drive_pair(fill(1), fill(1), 0, 1);
    drain();

    g = fill(0);
    for (int c = 0; c < 4; c++) g[0][c] = 8'd1;
    drive_pair(g, fill(0), 0, 1);
    drain();

    p1x = rnd_blk(); p1y = rnd_blk();
    p2x = rnd_blk(); p2y = rnd_blk();
    p3x = rnd_blk(); p3y = rnd_blk();
    drive_pair(p1x, p1y, 0, 1);
    tick();
    chk_busy = 1'b1;
    repeat (2) tick();
    drive_pair(p2x, p2y, 0, 1);
    repeat (3) tick();
    drive_pair(p3x, p3y, 0, 1);
    repeat (4) tick();
    chk_busy = 1'b0;
    drain();
    chk("b2b_ovf", ovf_o, 0);

    drive_gx(fill(1));
    drive_gx(fill(2));
    tick();
    chk("overrun_ovf_set", ovf_o, 1);
    push(fill(2), fill(0));
    drive_gy(fill(0));
    drain();
    repeat (3) tick();
    chk("overrun_ovf_sticky", ovf_o, 1);

    drive_pair(fill(5), fill(5), 0, 0);
    repeat (3) tick();
    chk("mid_busy_row2", busy_o, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("post_reset_idle", busy_o, 0);
    drive_pair(fill(-1), fill(4), 0, 1);
    drain();

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
